// File: rtl/uart_rx.sv
// UART receiver: 8 data bits (LSB first), one parity bit, one stop bit, mid-bit sampling.
// Delivers each good byte with a one-cycle ready strobe and exposes the FSM state for debug.
module uart_rx #(
   parameter int CLK_FREQ = 125_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   input  logic       PARITY,
   output logic [7:0] RX_DATA,
   output logic       RX_DATA_RDY,
   output logic [1:0] fsm_state
);

   localparam int BIT_CNT  = CLK_FREQ / BAUD;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CW       = $clog2(BIT_CNT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rxs, rxs_d;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [8:0]    shreg;
   logic          cnt_clr, shift_en, bit_clr, stop_smp, frame_good;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      bit_clr   = 1'b0;
      stop_smp  = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (rxs_d && !rxs) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_clr = 1'b1;
               if (!rxs) begin
                  bit_clr   = 1'b1;
                  state_nxt = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 4'd8) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_clr   = 1'b1;
               stop_smp  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // shreg holds {parity, data[7:0]} once all nine samples are in, so ^shreg covers both
   assign frame_good = stop_smp && rxs && ((^shreg) == PARITY);

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta     <= 1'b1;
         rxs         <= 1'b1;
         rxs_d       <= 1'b1;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         RX_DATA     <= 8'h00;
         RX_DATA_RDY <= 1'b0;
      end else begin
         rx_meta     <= RXD;
         rxs         <= rx_meta;
         rxs_d       <= rxs;
         cnt         <= cnt_clr ? '0 : cnt + 1'b1;
         RX_DATA_RDY <= frame_good;
         if (bit_clr)         bit_idx <= '0;
         else if (shift_en)   bit_idx <= bit_idx + 1'b1;
         if (shift_en)        shreg   <= {rxs, shreg[8:1]};
         if (frame_good)      RX_DATA <= shreg[7:0];
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes popped on each ready strobe,
// plus state-sequence, latency, bad-frame, glitch and mid-frame reset checks.
module tb_uart_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int BIT      = CLK_FREQ / BAUD;   // 16 clocks per bit
   localparam int HALF     = BIT / 2;
   // 3 = two synchronizer flops plus the edge-detect flop before IDLE reacts
   localparam int LATENCY  = HALF + 10 * BIT + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       parity = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_rdy;
   logic [1:0] fsm_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses = 0;
   int start_cyc = 0;
   int rdy_cyc = 0;
   logic [7:0] sb[$];
   logic [1:0] seq[$];
   logic [1:0] last_state = 2'b00;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .CLK(clk), .RST(rst), .RXD(rxd), .PARITY(parity),
      .RX_DATA(rx_data), .RX_DATA_RDY(rx_data_rdy), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every strobe cycle and records state changes
   always @(negedge clk) begin
      if (!rst && rx_data_rdy) begin
         pulses++;
         rdy_cyc = cyc;
         if (sb.size() == 0) check("rdy_unexpected", 32'd1, 32'd0);
         else                check("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
      end
      if (fsm_state != last_state) begin
         seq.push_back(fsm_state);
         last_state = fsm_state;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called right after a negedge; leaves the line idle for gap clocks after the stop bit
   task automatic send(input logic [7:0] d, input logic pb, input logic stop_bit, input int gap);
      rxd = 1'b0;
      start_cyc = cyc;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = pb;
      repeat (BIT) @(negedge clk);
      rxd = stop_bit;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] d, input int gap);
      logic pb;
      pb = parity ? ~(^d) : (^d);
      sb.push_back(d);
      send(d, pb, 1'b1, gap);
   endtask

   initial begin
      int p0;
      repeat (4) @(negedge clk);
      check("rst_data", {24'd0, rx_data}, 32'h00);
      check("rst_rdy", {31'd0, rx_data_rdy}, 32'd0);
      check("rst_state", {30'd0, fsm_state}, 32'd0);
      rst = 1'b0;
      repeat (2 * BIT) @(negedge clk);

      // Frame 1: 0xB8 even parity, state walk and latency
      seq.delete();
      p0 = pulses;
      send_good(8'hB8, 2 * BIT);
      check("f1_pulses", pulses - p0, 32'd1);
      check("f1_data", {24'd0, rx_data}, 32'hB8);
      check("f1_latency", rdy_cyc - start_cyc, LATENCY);
      check("f1_seq_len", seq.size(), 32'd4);
      if (seq.size() == 4) begin
         check("f1_seq0", {30'd0, seq[0]}, 32'd1);
         check("f1_seq1", {30'd0, seq[1]}, 32'd2);
         check("f1_seq2", {30'd0, seq[2]}, 32'd3);
         check("f1_seq3", {30'd0, seq[3]}, 32'd0);
      end

      // Frame 2: 0xB8 odd parity (parity bit 1)
      parity = 1'b1;
      p0 = pulses;
      send_good(8'hB8, 2 * BIT);
      check("f2_pulses", pulses - p0, 32'd1);
      parity = 1'b0;

      // Wrong parity bit: 0x5A has four ones, even parity bit should be 0
      p0 = pulses;
      send(8'h5A, 1'b1, 1'b1, 2 * BIT);
      check("badpar_pulses", pulses - p0, 32'd0);
      check("badpar_hold", {24'd0, rx_data}, 32'hB8);
      check("badpar_idle", {30'd0, fsm_state}, 32'd0);

      // Stop bit 0
      p0 = pulses;
      send(8'h5A, 1'b0, 1'b0, 2 * BIT);
      check("badstop_pulses", pulses - p0, 32'd0);
      check("badstop_hold", {24'd0, rx_data}, 32'hB8);
      check("badstop_idle", {30'd0, fsm_state}, 32'd0);

      // Short low glitch: enters START, rejected at the mid-sample
      seq.delete();
      p0 = pulses;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("glitch_pulses", pulses - p0, 32'd0);
      check("glitch_seq_len", seq.size(), 32'd2);
      if (seq.size() == 2) begin
         check("glitch_seq0", {30'd0, seq[0]}, 32'd1);
         check("glitch_seq1", {30'd0, seq[1]}, 32'd0);
      end

      // Reset in the middle of DATA
      p0 = pulses;
      rxd = 1'b0;
      for (int i = 0; i < 4 * BIT && fsm_state != 2'b10; i++) @(negedge clk);
      check("reach_data", {30'd0, fsm_state}, 32'd2);
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_state", {30'd0, fsm_state}, 32'd0);
      check("abort_data", {24'd0, rx_data}, 32'h00);
      rst = 1'b0;
      repeat (2 * BIT) @(negedge clk);
      check("abort_pulses", pulses - p0, 32'd0);
      send_good(8'h3C, 2 * BIT);
      check("after_rst_pulses", pulses - p0, 32'd1);
      check("after_rst_data", {24'd0, rx_data}, 32'h3C);

      // Back-to-back frames with no idle gap
      p0 = pulses;
      send_good(8'h01, 0);
      send_good(8'hFF, 2 * BIT);
      check("b2b_pulses", pulses - p0, 32'd2);
      check("b2b_last", {24'd0, rx_data}, 32'hFF);
      check("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
